// File: rtl/cw_deserializer_if.sv
// Bus bundle for cw_deserializer: serial beat input side and parallel codeword output side.
// Valid/ready: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface cw_deserializer_if #(
  parameter int N_V  = 44,
  parameter int IN_W = 4
) ();
  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_last;
  logic            in_ready;
  logic [N_V-1:0]  out_cw;
  logic            out_valid;
  logic            out_ready;
  logic            err_frame;

  // Environment side: drives beats, consumes codewords.
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_cw, out_valid, err_frame
  );

  // Deserializer side.
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_cw, out_valid, err_frame
  );
endinterface

// File: rtl/cw_deserializer.sv
// Serial-beat to N_V-bit codeword deserializer with assembly + output double buffering.
// Optional framing check on in_last enabled by defining CW_DESER_FRAME_CHK_EN.
module cw_deserializer #(
  parameter int N_V  = 44,
  parameter int IN_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  cw_deserializer_if.slave  cw_io,
  output logic              state_o
);
  localparam int NB = (N_V + IN_W - 1) / IN_W;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;
  logic [N_V-1:0] asm_q, asm_d;
  logic [N_V-1:0] out_cw_q, out_cw_d;
  logic           out_valid_q, out_valid_d;

  logic accept, last_beat, out_free, out_take;
  logic early_last, missing_last;

  assign accept    = cw_io.in_valid && (state_q == S_FILL);
  assign last_beat = (bcnt_q == BW'(NB - 1));
  assign out_take  = out_valid_q && cw_io.out_ready;
  assign out_free  = !out_valid_q || cw_io.out_ready;

`ifdef CW_DESER_FRAME_CHK_EN
  logic err_q;

  assign early_last   = accept && cw_io.in_last && !last_beat;
  assign missing_last = accept && !cw_io.in_last && last_beat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= early_last || missing_last;
  end

  assign cw_io.err_frame = err_q;
`else
  logic unused_in_last;

  assign early_last      = 1'b0;
  assign missing_last    = 1'b0;
  assign unused_in_last  = cw_io.in_last;
  assign cw_io.err_frame = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    asm_d       = asm_q;
    out_cw_d    = out_cw_q;
    out_valid_d = out_valid_q;

    // Beat k lands at bits [k*IN_W +: IN_W]; positions past N_V on the final beat are dropped.
    if (accept) begin
      for (int k = 0; k < NB; k++) begin
        for (int j = 0; j < IN_W; j++) begin
          if ((k * IN_W + j < N_V) && (bcnt_q == BW'(k))) asm_d[k * IN_W + j] = cw_io.in_data[j];
        end
      end
    end

    if (out_take) out_valid_d = 1'b0;

    unique case (state_q)
      S_FILL: begin
        if (accept) begin
          if (early_last) begin
            bcnt_d = '0;
          end else if (last_beat) begin
            bcnt_d = '0;
            if (out_free) begin
              out_cw_d    = asm_d;
              out_valid_d = 1'b1;
            end else begin
              state_d = S_FULL;
            end
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
      S_FULL: begin
        if (out_free) begin
          out_cw_d    = asm_q;
          out_valid_d = 1'b1;
          state_d     = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_FILL;
      bcnt_q      <= '0;
      asm_q       <= '0;
      out_cw_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      asm_q       <= asm_d;
      out_cw_q    <= out_cw_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign cw_io.in_ready  = (state_q == S_FILL);
  assign cw_io.out_cw    = out_cw_q;
  assign cw_io.out_valid = out_valid_q;
  assign state_o         = state_q;

endmodule

// File: doc/cw_deserializer.md
# cw_deserializer

Assembles a hard-decision codeword that arrives as narrow serial beats into a full N_V-bit parallel word for the min-sum decoder front end. It sits directly upstream of the bit-to-LLR mapping stage and drives that stage's `cw` input. Buffering is two-deep (assembly register plus output register), so a new codeword streams in while the previous one waits for the decoder.

## Interface
- `N_V`, 44: codeword length in bits (variable nodes).
- `IN_W`, 4: bits per input beat; 1 ≤ IN_W ≤ N_V.
- Derived `NB = ceil(N_V/IN_W)`: beats per codeword.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_data`  in  IN_W  codeword bits for the current beat.
- `in_valid`  in  1  `in_data` is valid.
- `in_last`  in  1  marks the final beat of a codeword.
- `in_ready`  out  1  block accepts a beat this cycle.
- `out_cw`  out  N_V  assembled codeword; bit i is variable node i.
- `out_valid`  out  1  `out_cw` holds an undelivered codeword.
- `out_ready`  in  1  downstream takes `out_cw` this cycle.
- `err_frame`  out  1  one-cycle pulse on a framing error.

## Operation
- A beat is accepted when `in_valid && in_ready` at a rising edge. An output word is consumed when `out_valid && out_ready`.
- Bit order is LSB first:
  - Beat k (0-based) writes assembly bits `[k*IN_W +: IN_W]`.
  - On the final beat, bits at positions ≥ N_V are discarded.
- Beat counter `bcnt` runs 0..NB-1 and returns to 0 after every completed or discarded codeword.
- States:
  - **FILL**: `in_ready=1`; accepting beats.
  - **FULL**: the assembly register holds a complete word blocked by an occupied output register; `in_ready=0`.
- Completion: a beat is accepted with `bcnt==NB-1`.
  - If the output register is empty, or is being consumed the same cycle, the completed word (including the current beat) is loaded into `out_cw` at that edge and `out_valid` is set. The state stays FILL.
  - Otherwise the state goes to FULL.
- In FULL, on the first cycle where the output register is empty or consumed, the assembly word moves to `out_cw`, `out_valid` stays or becomes 1, and the state returns to FILL with `bcnt=0`.
- `out_valid` clears on consumption only when no new word is loaded the same edge.
- `out_cw` is stable while `out_valid && !out_ready`.
- The assembly register is not cleared between words. Stale bits are always fully overwritten before completion.

## Timing
- Reset values: `out_cw=0`, `out_valid=0`, `err_frame=0`, `bcnt=0`, state FILL, `in_ready=1`. Beats are sampled only while `rst` is high.
- Latency: `out_valid` rises on the edge that accepts the completing beat (one clock after that beat is presented).
- Throughput: one beat per cycle sustained while `out_ready` is high, with no bubbles between codewords.
- With `out_ready` low, the block absorbs one full extra codeword, then deasserts `in_ready` (FULL).
- FULL plus `out_ready` high in the same cycle: the transfer happens at that edge and `in_ready=1` on the next cycle.
- Reset asserted mid-codeword aborts it immediately: partial beats are lost and the output word is dropped.

## Configuration
- `CW_DESER_FRAME_CHK_EN` defined: `in_last` is checked on every accepted beat.
  - Early last (`in_last=1` with `bcnt<NB-1`): the partial word is discarded, `bcnt←0`, and `err_frame` pulses the next cycle.
  - Missing last (`bcnt==NB-1` with `in_last=0`): the word is still completed and delivered normally, and `err_frame` pulses.
- Not defined: `in_last` is ignored, framing relies solely on `bcnt`, and `err_frame` is tied 0.

## Test plan
- Reset, then N_V=44, IN_W=4, 11 beats of `4'hA` with `out_ready=1` → `out_valid` rises after the 11th beat, `out_cw=44'hAAAAAAAAAAA`, `in_ready` constantly 1.
- `out_ready=0`, stream 3 codewords back-to-back → first word held stable; second word completes and `in_ready` drops. Raise `out_ready` → words delivered in order with no corruption, and `in_ready` returns the cycle after the transfer.
- IN_W=3 (NB=15), last beat `3'b111` → `out_cw[43:42]=2'b11`; the padding bit does not affect output.
- With `CW_DESER_FRAME_CHK_EN`, `in_last` on beat 5 → `err_frame` pulses once and no word is output. The next 11 clean beats produce a correct word.
- Assert `rst` after 6 beats with a word pending on the output → `out_valid=0`, `out_cw=0`, `in_ready=1`. The next full codeword is assembled correctly from beat 0.
- Simultaneous completion and consumption: `out_valid=1`, `out_ready=1` on the completing beat → new word replaces the old at the same edge, and `out_valid` stays 1 with no gap.
